// File: rtl/int_ctrl_vec.sv
// ---------------------------------------------------------------------------
// int_ctrl_vec
//   Vectored interrupt controller sitting on a Wishbone slave port between
//   peripheral interrupt lines and the single CPU interrupt pin. Each channel
//   can be edge or level triggered with programmable polarity, and the
//   highest-priority (lowest-index) pending channel is reported in IVR.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   sa_dat_i/sa_dat_o  Wishbone write data / registered read data
//   sa_sel_i           byte select (unused, all writes are full-word)
//   sa_addr_i          register word address
//   sa_stb_i, sa_we_i  strobe and write enable
//   sa_ack_o           single-cycle acknowledge, one wait state
//   sa_err_o, sa_rty_o tied low
//   int_i              raw interrupt lines, synchronous to clk
//   int_o              registered CPU interrupt request
//
// Register map (word address):
//   0 MER  1 IER  2 IAR  3 IPR  4 IMR  5 IPOL  6 IVR  7 reserved
// ---------------------------------------------------------------------------
module int_ctrl_vec #(
  parameter int                 INT_NUM  = 3,
  parameter int                 Dw       = 32,
  parameter int                 Aw       = 3,
  parameter int                 SELw     = 4,
  parameter logic [INT_NUM-1:0] EDGE_RST = '0,
  parameter logic [INT_NUM-1:0] POL_RST  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Dw-1:0]      sa_dat_i,
  input  logic [SELw-1:0]    sa_sel_i,
  input  logic [Aw-1:0]      sa_addr_i,
  input  logic               sa_stb_i,
  input  logic               sa_we_i,
  output logic [Dw-1:0]      sa_dat_o,
  output logic               sa_ack_o,
  output logic               sa_err_o,
  output logic               sa_rty_o,
  input  logic [INT_NUM-1:0] int_i,
  output logic               int_o
);

  // Register state
  logic [1:0]         mer_q;
  logic [INT_NUM-1:0] ier_q;
  logic [INT_NUM-1:0] iar_q, iar_d;
  logic [INT_NUM-1:0] ipr_q, ipr_d;
  logic [INT_NUM-1:0] imr_q;
  logic [INT_NUM-1:0] ipol_q;
  logic [INT_NUM-1:0] prev_q;
  logic [Dw-1:0]      dat_q;
  logic               ack_q;
  logic               int_q;

  // Derived combinational signals
  logic               capture;
  logic               wr_en;
  logic               rd_en;
  logic [INT_NUM-1:0] wdata;
  logic [INT_NUM-1:0] lvl;
  logic [INT_NUM-1:0] rise;
  logic [INT_NUM-1:0] iar_clr;
  logic [INT_NUM-1:0] pend;
  logic [4:0]         vec_idx;
  logic [Dw-1:0]      ivr;
  logic [Dw-1:0]      rdata;
  logic               int_d;

  // Byte selects and write-data bits above the channel count have no effect.
  logic unused_bits;
  assign unused_bits = ^{sa_sel_i, sa_dat_i};

  // An access is taken only in the first strobe cycle, before the ack goes
  // out, so a strobe held across several cycles cannot apply a write twice
  // within one acknowledged transfer.
  assign capture = sa_stb_i & ~ack_q;
  assign wr_en   = capture & sa_we_i;
  assign rd_en   = capture & ~sa_we_i;
  assign wdata   = sa_dat_i[INT_NUM-1:0];

  // Polarity-normalised line level and its rising edge against last cycle.
  assign lvl     = int_i ^ ipol_q;
  assign rise    = lvl & ~prev_q;
  assign iar_clr = (wr_en && (sa_addr_i == Aw'(2))) ? wdata : '0;
  assign pend    = ipr_q & ier_q;

  // Pending next state. Edge channels latch an enabled rise and are cleared
  // by a write-1 to IAR, with a simultaneous rise taking precedence. Level
  // channels simply follow the enabled line. A disabled channel always clears.
  always_comb begin
    ipr_d = (imr_q & ier_q & (rise | (ipr_q & ~iar_clr)))
          | (~imr_q & ier_q & lvl);
  end

  // Acknowledge bookkeeping: a write-1 marks a channel acknowledged and a
  // fresh rise on that channel withdraws the mark.
  always_comb begin
    iar_d = (iar_q | iar_clr) & ~rise;
  end

  // Interrupt vector: valid flag in the MSB and the index of the lowest
  // numbered pending channel in the low five bits. Scanning downwards lets
  // the lowest index overwrite any higher one.
  always_comb begin
    vec_idx = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (pend[i]) vec_idx = 5'(i);
    end
    ivr        = '0;
    ivr[4:0]   = vec_idx;
    ivr[Dw-1]  = |pend;
  end

  // Read data multiplexer, zero-extending the narrow registers to bus width.
  always_comb begin
    rdata = '0;
    case (sa_addr_i)
      Aw'(0):  rdata = Dw'(mer_q);
      Aw'(1):  rdata = Dw'(ier_q);
      Aw'(2):  rdata = Dw'(iar_q);
      Aw'(3):  rdata = Dw'(ipr_q);
      Aw'(4):  rdata = Dw'(imr_q);
      Aw'(5):  rdata = Dw'(ipol_q);
      Aw'(6):  rdata = ivr;
      default: rdata = '0;
    endcase
  end

  // CPU request is only raised when both master enable bits are set.
  assign int_d = (mer_q == 2'b11) & (|pend);

  // All state, including the bus handshake, resets synchronously. Clearing
  // prev means a line already active at reset release is seen as a new rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mer_q  <= '0;
      ier_q  <= '0;
      iar_q  <= '0;
      ipr_q  <= '0;
      imr_q  <= EDGE_RST;
      ipol_q <= POL_RST;
      prev_q <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      ack_q  <= sa_stb_i & ~ack_q;
      prev_q <= lvl;
      ipr_q  <= ipr_d;
      iar_q  <= iar_d;
      int_q  <= int_d;
      if (rd_en) dat_q <= rdata;
      if (wr_en) begin
        case (sa_addr_i)
          Aw'(0):  mer_q  <= sa_dat_i[1:0];
          Aw'(1):  ier_q  <= wdata;
          Aw'(4):  imr_q  <= wdata;
          Aw'(5):  ipol_q <= wdata;
          default: ;
        endcase
      end
    end
  end

  assign sa_dat_o = dat_q;
  assign sa_ack_o = ack_q;
  assign sa_err_o = 1'b0;
  assign sa_rty_o = 1'b0;
  assign int_o    = int_q;

endmodule

// File: tb/tb_int_ctrl_vec.sv
// ---------------------------------------------------------------------------
// tb_int_ctrl_vec
//   Directed bench for int_ctrl_vec with three channels. Inputs change one
//   time unit after each rising edge and outputs are observed at the same
//   point, so every observation reflects state after the preceding edge.
// ---------------------------------------------------------------------------
module tb_int_ctrl_vec;

  localparam int         INT_NUM  = 3;
  localparam int         Dw       = 32;
  localparam int         Aw       = 3;
  localparam int         SELw     = 4;
  localparam logic [2:0] EDGE_RST = 3'b100;
  localparam logic [2:0] POL_RST  = 3'b010;

  logic               clk;
  logic               reset;
  logic [Dw-1:0]      sa_dat_i;
  logic [SELw-1:0]    sa_sel_i;
  logic [Aw-1:0]      sa_addr_i;
  logic               sa_stb_i;
  logic               sa_we_i;
  logic [Dw-1:0]      sa_dat_o;
  logic               sa_ack_o;
  logic               sa_err_o;
  logic               sa_rty_o;
  logic [INT_NUM-1:0] int_i;
  logic               int_o;

  int checks = 0;
  int errors = 0;

  int_ctrl_vec #(
    .INT_NUM (INT_NUM),
    .Dw      (Dw),
    .Aw      (Aw),
    .SELw    (SELw),
    .EDGE_RST(EDGE_RST),
    .POL_RST (POL_RST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sa_dat_i (sa_dat_i),
    .sa_sel_i (sa_sel_i),
    .sa_addr_i(sa_addr_i),
    .sa_stb_i (sa_stb_i),
    .sa_we_i  (sa_we_i),
    .sa_dat_o (sa_dat_o),
    .sa_ack_o (sa_ack_o),
    .sa_err_o (sa_err_o),
    .sa_rty_o (sa_rty_o),
    .int_i    (int_i),
    .int_o    (int_o)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the raw interrupt lines.
  task automatic applyStimulus(input logic [INT_NUM-1:0] lines);
    int_i = lines;
  endtask

  // Full write transfer: capture edge, then the edge where ack drops.
  task automatic busWrite(input logic [Aw-1:0] a, input logic [Dw-1:0] d);
    sa_addr_i = a;
    sa_dat_i  = d;
    sa_we_i   = 1'b1;
    sa_stb_i  = 1'b1;
    tick();
    checkOutput("wr_ack_hi", 32'(sa_ack_o), 32'd1);
    sa_stb_i  = 1'b0;
    sa_we_i   = 1'b0;
    tick();
    checkOutput("wr_ack_lo", 32'(sa_ack_o), 32'd0);
  endtask

  // Full read transfer returning the registered read data.
  task automatic busRead(input logic [Aw-1:0] a, output logic [Dw-1:0] d);
    sa_addr_i = a;
    sa_we_i   = 1'b0;
    sa_stb_i  = 1'b1;
    tick();
    checkOutput("rd_ack_hi", 32'(sa_ack_o), 32'd1);
    d         = sa_dat_o;
    sa_stb_i  = 1'b0;
    tick();
    checkOutput("rd_ack_lo", 32'(sa_ack_o), 32'd0);
  endtask

  logic [Dw-1:0] rd;
  logic [Dw-1:0] resetExp [8];

  initial begin
    reset     = 1'b1;
    sa_dat_i  = '0;
    sa_sel_i  = '1;
    sa_addr_i = '0;
    sa_stb_i  = 1'b0;
    sa_we_i   = 1'b0;
    int_i     = '0;
    tick();
    tick();
    checkOutput("rst_ack", 32'(sa_ack_o), 32'd0);
    checkOutput("rst_int", 32'(int_o), 32'd0);
    checkOutput("rst_dat", sa_dat_o, 32'd0);
    checkOutput("err_tie", 32'({sa_err_o, sa_rty_o}), 32'd0);
    reset = 1'b0;
    tick();

    // Reset values of the whole register map.
    $display("[TB] reset register map");
    resetExp = '{32'd0, 32'd0, 32'd0, 32'd0, 32'(EDGE_RST), 32'(POL_RST), 32'd0, 32'd0};
    for (int a = 0; a < 8; a++) begin
      busRead(3'(a), rd);
      checkOutput($sformatf("rst_reg%0d", a), rd, resetExp[a]);
    end

    // Edge channel 1: one-cycle pulse, latency to int_o, then IAR clear.
    $display("[TB] edge channel");
    busWrite(3'd5, 32'h0);
    busWrite(3'd4, 32'h7);
    busWrite(3'd1, 32'h7);
    busWrite(3'd0, 32'h3);
    applyStimulus(3'b010);
    tick();
    applyStimulus(3'b000);
    checkOutput("edge_int_k", 32'(int_o), 32'd0);
    tick();
    checkOutput("edge_int_k1", 32'(int_o), 32'd1);
    busRead(3'd3, rd);
    checkOutput("edge_ipr", rd, 32'h2);
    busRead(3'd6, rd);
    checkOutput("edge_ivr", rd, 32'h8000_0001);
    sa_addr_i = 3'd2;
    sa_dat_i  = 32'h2;
    sa_we_i   = 1'b1;
    sa_stb_i  = 1'b1;
    tick();
    sa_stb_i  = 1'b0;
    sa_we_i   = 1'b0;
    checkOutput("clr_int_k", 32'(int_o), 32'd1);
    tick();
    checkOutput("clr_int_k1", 32'(int_o), 32'd0);
    busRead(3'd3, rd);
    checkOutput("clr_ipr", rd, 32'h0);
    busRead(3'd2, rd);
    checkOutput("clr_iar", rd, 32'h2);

    // Level channel 0: IAR writes do not clear it, dropping the line does.
    $display("[TB] level channel");
    busWrite(3'd4, 32'h0);
    busWrite(3'd1, 32'h1);
    applyStimulus(3'b001);
    tick();
    checkOutput("lvl_int_k", 32'(int_o), 32'd0);
    tick();
    checkOutput("lvl_int_k1", 32'(int_o), 32'd1);
    busRead(3'd3, rd);
    checkOutput("lvl_ipr", rd, 32'h1);
    busWrite(3'd2, 32'h1);
    busRead(3'd3, rd);
    checkOutput("lvl_ipr_iar", rd, 32'h1);
    applyStimulus(3'b000);
    tick();
    checkOutput("lvl_drop_k", 32'(int_o), 32'd1);
    tick();
    checkOutput("lvl_drop_k1", 32'(int_o), 32'd0);
    busRead(3'd3, rd);
    checkOutput("lvl_drop_ipr", rd, 32'h0);
    busRead(3'd2, rd);
    checkOutput("lvl_iar", rd, 32'h3);

    // Priority with inverted polarity on channel 2.
    $display("[TB] priority and polarity");
    busWrite(3'd5, 32'h4);
    busWrite(3'd1, 32'h7);
    applyStimulus(3'b010);
    tick();
    busRead(3'd6, rd);
    checkOutput("prio_ivr1", rd, 32'h8000_0001);
    busRead(3'd3, rd);
    checkOutput("prio_ipr", rd, 32'h6);
    applyStimulus(3'b011);
    tick();
    busRead(3'd6, rd);
    checkOutput("prio_ivr0", rd, 32'h8000_0000);

    // Rise on edge channel 2 coincident with its IAR clear: the set wins.
    $display("[TB] simultaneous set and clear");
    applyStimulus(3'b000);
    busWrite(3'd5, 32'h0);
    busWrite(3'd4, 32'h4);
    busWrite(3'd1, 32'h4);
    busRead(3'd3, rd);
    checkOutput("sim_ipr_pre", rd, 32'h0);
    applyStimulus(3'b100);
    tick();
    applyStimulus(3'b000);
    tick();
    applyStimulus(3'b100);
    sa_addr_i = 3'd2;
    sa_dat_i  = 32'h4;
    sa_we_i   = 1'b1;
    sa_stb_i  = 1'b1;
    tick();
    sa_stb_i  = 1'b0;
    sa_we_i   = 1'b0;
    applyStimulus(3'b000);
    tick();
    checkOutput("sim_int", 32'(int_o), 32'd1);
    busRead(3'd3, rd);
    checkOutput("sim_ipr", rd, 32'h4);
    busWrite(3'd0, 32'h1);
    checkOutput("mer01_int", 32'(int_o), 32'd0);

    // Held strobe produces an alternating ack and clears the pending bit.
    $display("[TB] held strobe");
    sa_addr_i = 3'd2;
    sa_dat_i  = 32'h4;
    sa_we_i   = 1'b1;
    sa_stb_i  = 1'b1;
    tick();
    checkOutput("hold_ack0", 32'(sa_ack_o), 32'd1);
    tick();
    checkOutput("hold_ack1", 32'(sa_ack_o), 32'd0);
    tick();
    checkOutput("hold_ack2", 32'(sa_ack_o), 32'd1);
    tick();
    checkOutput("hold_ack3", 32'(sa_ack_o), 32'd0);
    sa_stb_i  = 1'b0;
    sa_we_i   = 1'b0;
    busRead(3'd3, rd);
    checkOutput("hold_ipr", rd, 32'h0);

    // Reset arriving while a read is being acknowledged.
    $display("[TB] reset mid-transaction");
    applyStimulus(3'b100);
    tick();
    applyStimulus(3'b000);
    busWrite(3'd0, 32'h3);
    checkOutput("pre_rst_int", 32'(int_o), 32'd1);
    sa_addr_i = 3'd3;
    sa_we_i   = 1'b0;
    sa_stb_i  = 1'b1;
    tick();
    checkOutput("pre_rst_ack", 32'(sa_ack_o), 32'd1);
    checkOutput("pre_rst_dat", sa_dat_o, 32'h4);
    reset    = 1'b1;
    sa_stb_i = 1'b0;
    tick();
    checkOutput("mid_rst_ack", 32'(sa_ack_o), 32'd0);
    checkOutput("mid_rst_int", 32'(int_o), 32'd0);
    checkOutput("mid_rst_dat", sa_dat_o, 32'd0);
    reset = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) begin
      busRead(3'(a), rd);
      checkOutput($sformatf("post_rst_reg%0d", a), rd, resetExp[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
